i2c_apb_regfile: RTL and testbench
==================================

# i2c_apb_regfile

Parametrised APB4 slave register file for the I2C core, the next generation of the I2C APB register interface. It decodes word-aligned APB accesses into the I2C control registers. It generates single-cycle TX-FIFO push and RX-FIFO pop strobes and supports programmable wait states, byte strobes and PSLVERR. It also collects core events into a maskable, write-one-to-clear interrupt. It sits between the system APB fabric and the I2C core/FIFOs.

## Interface
- DATA_WIDTH, 32, APB data width; 16 or 32.
- ADDR_WIDTH, 8, APB address width; word index is paddr_i[ADDR_WIDTH-1:2].
- PRESCALE_WIDTH, 16, prescale register width; at most 16.
- WAIT_STATES, 0, pready_o low cycles per access; 0..3.
- pclk_i  in  1  clock.
- preset_i  in  1  reset; synchronous, active-high.
- paddr_i / pwrite_i / psel_i / penable_i  in  ADDR_WIDTH/1/1/1  APB controls.
- pwdata_i  in  DATA_WIDTH  write data.
- pstrb_i  in  DATA_WIDTH/8  write byte strobes.
- prdata_o  out  DATA_WIDTH  read data, registered.
- pready_o / pslverr_o  out  1/1  transfer complete / error.
- status_i  in  8  FIFO/core status.
- rx_data_i  in  8  RX-FIFO head.
- rx_empty_i  in  1  RX-FIFO empty.
- event_i  in  4  core event pulses.
- tx_push_o / tx_data_o  out  1/8  TX-FIFO write strobe and data.
- rx_pop_o  out  1  RX-FIFO read strobe.
- reg_slave_address_o / reg_command_o  out  8/8  register values.
- reg_prescale_o  out  PRESCALE_WIDTH  register value.
- irq_o  out  1  interrupt.

## Operation
- Register map (byte offset): 0x00 TX (RW), 0x04 RX (RO), 0x08 STATUS (RO), 0x0C SLV_ADDR (RW), 0x10 CMD (RW), 0x14 PRESCALE (RW), 0x18 IRQ_EN (RW, 4b), 0x1C IRQ_STAT (R/W1C, 4b). Unused read bits are 0.
- Access FSM: IDLE -> ACCESS on a setup cycle (psel_i=1, penable_i=0).
- In ACCESS with psel_i and penable_i high, wait_cnt counts up. The access completes in the cycle where wait_cnt==WAIT_STATES, with pready_o=1. It then returns to IDLE, or goes straight to ACCESS if a new setup follows.
- In ACCESS, psel_i=0 or penable_i=0 aborts: the FSM returns to IDLE with no side effects.
- psel_i&penable_i in IDLE (no setup) is unsequenced: pready_o=1, pslverr_o=1, no side effects.
- Side effects occur only at completion.
- Write: each register field updates only where the matching pstrb_i lane is set; PRESCALE uses lanes 0 and 1.
- TX write: stores the byte and asserts tx_push_o for one cycle with tx_data_o.
- Read: prdata_o is loaded at the end of the setup cycle. It must be stable through the access.
- RX read completion: rx_pop_o pulses for one cycle, unless rx_empty_i was 1 at setup.
- pslverr_o=1 at completion for any of: unmapped offset, write to RX/STATUS, RX read while empty, write with pstrb_i==0. Erroring accesses have no side effects.
- IRQ_STAT bit i sets on event_i[i]. It clears on a completed write of 1 to that bit. Set wins when set and clear happen in the same cycle.
- irq_o = |(IRQ_STAT & IRQ_EN).
- Reset: all registers 0, FSM IDLE, wait_cnt 0. All outputs 0 except pready_o, which follows the rule above.

## Timing
- WAIT_STATES=0: setup at cycle N, completion at N+1; register update and strobes are visible after edge N+1.
- Each wait state adds one cycle; pready_o is combinational from FSM state and wait_cnt.
- tx_push_o / rx_pop_o are exactly one cycle wide, issued in the cycle after completion. Back-to-back accesses give one strobe each.
- An event pulse at cycle N sets IRQ_STAT after edge N; irq_o is combinational from flops.
- preset_i mid-access: the FSM returns to IDLE next edge; no strobe is issued.

## Structure
- Package i2c_apb_pkg: register offset constants, IRQ bit indices, FSM state enum (IDLE, ACCESS).
- Sub-module i2c_apb_access_fsm: state, wait counter, pready/completion/abort.

## Test plan
- WAIT_STATES=0: write 0xA5 to 0x00 -> tx_push_o one cycle with tx_data_o=0xA5; read 0x00 -> 0xA5, pslverr_o=0.
- WAIT_STATES=2: write PRESCALE 0x1234 with pstrb=4'b0001 -> pready_o low 2 cycles; reg_prescale_o=0x0034.
- RX read with rx_empty_i=0, rx_data_i=0x5C -> prdata_o=0x5C, one rx_pop_o. Repeat with rx_empty_i=1 -> pslverr_o=1, no pop.
- Write 0x40 (unmapped) and write STATUS -> pslverr_o=1, no register change. Unsequenced penable -> pready_o=1, pslverr_o=1.
- IRQ_EN=0x2, event_i[1] pulse -> irq_o=1. W1C 0x2 coinciding with a new event_i[1] -> bit stays set.
- Assert preset_i during a wait state -> next cycle all outputs reset, no strobe.

Source files
------------

// File: rtl/i2c_apb_pkg.sv
// Shared definitions for the I2C APB register file: register map,
// interrupt bit positions and the access FSM state encoding.
package i2c_apb_pkg;

    // Byte offsets of the register map
    localparam int unsigned OFF_TX       = 32'h00;
    localparam int unsigned OFF_RX       = 32'h04;
    localparam int unsigned OFF_STATUS   = 32'h08;
    localparam int unsigned OFF_SLV_ADDR = 32'h0C;
    localparam int unsigned OFF_CMD      = 32'h10;
    localparam int unsigned OFF_PRESCALE = 32'h14;
    localparam int unsigned OFF_IRQ_EN   = 32'h18;
    localparam int unsigned OFF_IRQ_STAT = 32'h1C;

    // Word indices derived from the byte offsets (address bits [..:2])
    localparam int unsigned W_TX       = OFF_TX       >> 2;
    localparam int unsigned W_RX       = OFF_RX       >> 2;
    localparam int unsigned W_STATUS   = OFF_STATUS   >> 2;
    localparam int unsigned W_SLV_ADDR = OFF_SLV_ADDR >> 2;
    localparam int unsigned W_CMD      = OFF_CMD      >> 2;
    localparam int unsigned W_PRESCALE = OFF_PRESCALE >> 2;
    localparam int unsigned W_IRQ_EN   = OFF_IRQ_EN   >> 2;
    localparam int unsigned W_IRQ_STAT = OFF_IRQ_STAT >> 2;

    // Interrupt sources, one per event_i line
    localparam int unsigned IRQ_W    = 4;
    localparam int unsigned IRQ_EVT0 = 0;
    localparam int unsigned IRQ_EVT1 = 1;
    localparam int unsigned IRQ_EVT2 = 2;
    localparam int unsigned IRQ_EVT3 = 3;

    // Access sequencing states
    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

endpackage

// File: rtl/i2c_apb_access_fsm.sv
// APB access sequencer: tracks setup/access phases, inserts wait states,
// and flags completion, abort-free setup and unsequenced enables.
module i2c_apb_access_fsm
    import i2c_apb_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic pclk_i,
    input  logic preset_i,
    input  logic psel_i,
    input  logic penable_i,
    output logic setup_o,
    output logic complete_o,
    output logic unseq_o,
    output logic pready_o
);

    apb_state_e state_q, state_d;
    logic [1:0] wait_cnt_q, wait_cnt_d;
    logic       at_limit;

    assign at_limit = (wait_cnt_q == 2'(WAIT_STATES));

    // State register and wait counter
    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            state_q    <= IDLE;
            wait_cnt_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state logic; pready depends only on state/counter except for
    // the unsequenced-enable case, which is answered immediately.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        setup_o    = 1'b0;
        complete_o = 1'b0;
        unseq_o    = 1'b0;
        pready_o   = 1'b0;
        case (state_q)
            IDLE: begin
                wait_cnt_d = 2'd0;
                if (psel_i && !penable_i) begin
                    setup_o = 1'b1;
                    state_d = ACCESS;
                end else if (psel_i && penable_i) begin
                    unseq_o  = 1'b1;
                    pready_o = 1'b1;
                end
            end
            ACCESS: begin
                pready_o = at_limit;
                if (psel_i && penable_i) begin
                    if (at_limit) begin
                        complete_o = 1'b1;
                        state_d    = IDLE;
                        wait_cnt_d = 2'd0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 2'd1;
                    end
                end else begin
                    // Master dropped the transfer: leave without side effects
                    state_d    = IDLE;
                    wait_cnt_d = 2'd0;
                end
            end
            default: begin
                state_d    = IDLE;
                wait_cnt_d = 2'd0;
            end
        endcase
    end

endmodule

// File: rtl/i2c_apb_regfile.sv
// APB4 slave register file for the I2C core: control registers, TX push /
// RX pop strobes, error reporting and a maskable W1C interrupt.
module i2c_apb_regfile
    import i2c_apb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 16,
    parameter int unsigned WAIT_STATES    = 0
) (
    input  logic                      pclk_i,
    input  logic                      preset_i,
    input  logic [ADDR_WIDTH-1:0]     paddr_i,
    input  logic                      pwrite_i,
    input  logic                      psel_i,
    input  logic                      penable_i,
    input  logic [DATA_WIDTH-1:0]     pwdata_i,
    input  logic [DATA_WIDTH/8-1:0]   pstrb_i,
    output logic [DATA_WIDTH-1:0]     prdata_o,
    output logic                      pready_o,
    output logic                      pslverr_o,
    input  logic [7:0]                status_i,
    input  logic [7:0]                rx_data_i,
    input  logic                      rx_empty_i,
    input  logic [IRQ_W-1:0]          event_i,
    output logic                      tx_push_o,
    output logic [7:0]                tx_data_o,
    output logic                      rx_pop_o,
    output logic [7:0]                reg_slave_address_o,
    output logic [7:0]                reg_command_o,
    output logic [PRESCALE_WIDTH-1:0] reg_prescale_o,
    output logic                      irq_o
);

    logic                  setup, complete, unseq;
    logic                  rx_empty_q;
    logic [IRQ_W-1:0]      irq_en_q, irq_stat_q, irq_clr;
    int unsigned           widx;
    logic [DATA_WIDTH-1:0] rdata_mux;
    logic                  acc_err, wr_ok, rd_ok;
    logic                  unused_bits;

    i2c_apb_access_fsm #(
        .WAIT_STATES(WAIT_STATES)
    ) u_access_fsm (
        .pclk_i    (pclk_i),
        .preset_i  (preset_i),
        .psel_i    (psel_i),
        .penable_i (penable_i),
        .setup_o   (setup),
        .complete_o(complete),
        .unseq_o   (unseq),
        .pready_o  (pready_o)
    );

    assign widx        = 32'(paddr_i[ADDR_WIDTH-1:2]);
    assign unused_bits = ^{paddr_i[1:0], pwdata_i, pstrb_i};

    // Read mux and access error decode
    always_comb begin
        rdata_mux = '0;
        case (widx)
            W_TX:       rdata_mux[7:0]                = tx_data_o;
            W_RX:       rdata_mux[7:0]                = rx_data_i;
            W_STATUS:   rdata_mux[7:0]                = status_i;
            W_SLV_ADDR: rdata_mux[7:0]                = reg_slave_address_o;
            W_CMD:      rdata_mux[7:0]                = reg_command_o;
            W_PRESCALE: rdata_mux[PRESCALE_WIDTH-1:0] = reg_prescale_o;
            W_IRQ_EN:   rdata_mux[IRQ_W-1:0]          = irq_en_q;
            W_IRQ_STAT: rdata_mux[IRQ_W-1:0]          = irq_stat_q;
            default:    rdata_mux                     = '0;
        endcase
        // RX emptiness is judged on the value seen at setup time
        acc_err = (widx > W_IRQ_STAT)
                | (pwrite_i && (widx == W_RX || widx == W_STATUS))
                | (!pwrite_i && widx == W_RX && rx_empty_q)
                | (pwrite_i && pstrb_i == '0);
    end

    assign wr_ok     = complete && pwrite_i && !acc_err;
    assign rd_ok     = complete && !pwrite_i && !acc_err;
    assign pslverr_o = unseq || (complete && acc_err);
    assign irq_clr   = (wr_ok && widx == W_IRQ_STAT && pstrb_i[0]) ? pwdata_i[IRQ_W-1:0] : '0;
    assign irq_o     = |(irq_stat_q & irq_en_q);

    // Setup-time capture of read data and RX emptiness
    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            prdata_o   <= '0;
            rx_empty_q <= 1'b0;
        end else if (setup) begin
            rx_empty_q <= rx_empty_i;
            if (!pwrite_i) begin
                prdata_o <= rdata_mux;
            end
        end
    end

    // Register writes on completion, byte-lane qualified; TX pushes only
    // when its data byte actually landed.
    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            tx_data_o           <= '0;
            reg_slave_address_o <= '0;
            reg_command_o       <= '0;
            reg_prescale_o      <= '0;
            irq_en_q            <= '0;
            tx_push_o           <= 1'b0;
            rx_pop_o            <= 1'b0;
        end else begin
            tx_push_o <= 1'b0;
            rx_pop_o  <= rd_ok && (widx == W_RX);
            if (wr_ok) begin
                case (widx)
                    W_TX: begin
                        if (pstrb_i[0]) begin
                            tx_data_o <= pwdata_i[7:0];
                            tx_push_o <= 1'b1;
                        end
                    end
                    W_SLV_ADDR: if (pstrb_i[0]) reg_slave_address_o <= pwdata_i[7:0];
                    W_CMD:      if (pstrb_i[0]) reg_command_o       <= pwdata_i[7:0];
                    W_PRESCALE: begin
                        for (int i = 0; i < int'(PRESCALE_WIDTH); i++) begin
                            if (pstrb_i[i/8]) reg_prescale_o[i] <= pwdata_i[i];
                        end
                    end
                    W_IRQ_EN:   if (pstrb_i[0]) irq_en_q <= pwdata_i[IRQ_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Interrupt status: sticky events, write-one-to-clear, set wins
    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            irq_stat_q <= '0;
        end else begin
            irq_stat_q <= (irq_stat_q & ~irq_clr) | event_i;
        end
    end

endmodule

// File: tb/tb_i2c_apb_regfile.sv
// Testbench for i2c_apb_regfile: directed scenarios with literal
// expectations, then randomized APB traffic against a behavioural model.
module tb_i2c_apb_regfile;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int PW = 16;
    localparam int WS = 2;

    localparam int PH_IDLE  = 0;
    localparam int PH_SETUP = 1;
    localparam int PH_ACC   = 2;
    localparam int PH_ABORT = 3;
    localparam int PH_UNSEQ = 4;

    logic          pclk_i = 1'b0;
    logic          preset_i = 1'b1;
    logic [AW-1:0] paddr_i = '0;
    logic          pwrite_i = 1'b0;
    logic          psel_i = 1'b0;
    logic          penable_i = 1'b0;
    logic [DW-1:0] pwdata_i = '0;
    logic [3:0]    pstrb_i = '0;
    logic [DW-1:0] prdata_o;
    logic          pready_o, pslverr_o;
    logic [7:0]    status_i = '0;
    logic [7:0]    rx_data_i = '0;
    logic          rx_empty_i = 1'b1;
    logic [3:0]    event_i = '0;
    logic          tx_push_o, rx_pop_o, irq_o;
    logic [7:0]    tx_data_o, reg_slave_address_o, reg_command_o;
    logic [PW-1:0] reg_prescale_o;

    always #5 pclk_i = ~pclk_i;

    i2c_apb_regfile #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PRESCALE_WIDTH(PW), .WAIT_STATES(WS)
    ) dut (
        .pclk_i(pclk_i), .preset_i(preset_i), .paddr_i(paddr_i), .pwrite_i(pwrite_i),
        .psel_i(psel_i), .penable_i(penable_i), .pwdata_i(pwdata_i), .pstrb_i(pstrb_i),
        .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
        .status_i(status_i), .rx_data_i(rx_data_i), .rx_empty_i(rx_empty_i),
        .event_i(event_i), .tx_push_o(tx_push_o), .tx_data_o(tx_data_o),
        .rx_pop_o(rx_pop_o), .reg_slave_address_o(reg_slave_address_o),
        .reg_command_o(reg_command_o), .reg_prescale_o(reg_prescale_o), .irq_o(irq_o)
    );

    int total = 0;
    int bad   = 0;
    int ph    = PH_IDLE;
    int ph_k  = 0;
    bit chk_en  = 0;
    bit rand_in = 0;
    logic last_pready, last_err;
    int   low_cnt;

    // Behavioural model state
    logic [7:0]  m_tx, m_slv, m_cmd;
    logic [15:0] m_pre;
    logic [3:0]  m_en, m_stat;
    logic [31:0] m_prdata;
    logic        m_push, m_pop, m_empty;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_err(input logic [7:0] a, input bit wr, input logic [3:0] s, input bit empty);
        int w;
        w = int'(a) / 4;
        return (w > 7) || (wr && (w == 1 || w == 2)) || (!wr && w == 1 && empty) || (wr && s == 4'h0);
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        case (int'(a) / 4)
            0: return {24'h0, m_tx};
            1: return {24'h0, rx_data_i};
            2: return {24'h0, status_i};
            3: return {24'h0, m_slv};
            4: return {24'h0, m_cmd};
            5: return {16'h0, m_pre};
            6: return {28'h0, m_en};
            7: return {28'h0, m_stat};
            default: return 32'h0;
        endcase
    endfunction

    // Model: advance expected state from what the driver did this cycle
    always @(posedge pclk_i) begin : model
        logic [3:0] clr;
        int         w;
        if (preset_i) begin
            m_tx = 0; m_slv = 0; m_cmd = 0; m_pre = 0; m_en = 0; m_stat = 0;
            m_prdata = 0; m_push = 0; m_pop = 0; m_empty = 0;
        end else begin
            clr = 4'h0; m_push = 0; m_pop = 0;
            w = int'(paddr_i) / 4;
            if (ph == PH_SETUP) begin
                m_empty = rx_empty_i;
                if (!pwrite_i) m_prdata = m_read(paddr_i);
            end
            if (ph == PH_ACC && ph_k == WS && !m_err(paddr_i, pwrite_i, pstrb_i, m_empty)) begin
                if (pwrite_i) begin
                    case (w)
                        0: if (pstrb_i[0]) begin m_tx = pwdata_i[7:0]; m_push = 1; end
                        3: if (pstrb_i[0]) m_slv = pwdata_i[7:0];
                        4: if (pstrb_i[0]) m_cmd = pwdata_i[7:0];
                        5: begin
                            if (pstrb_i[0]) m_pre[7:0]  = pwdata_i[7:0];
                            if (pstrb_i[1]) m_pre[15:8] = pwdata_i[15:8];
                        end
                        6: if (pstrb_i[0]) m_en = pwdata_i[3:0];
                        7: if (pstrb_i[0]) clr = pwdata_i[3:0];
                        default: ;
                    endcase
                end else if (w == 1) begin
                    m_pop = 1;
                end
            end
            m_stat = (m_stat & ~clr) | event_i;
        end
    end

    // Compare every output against the model away from the active edge
    always @(negedge pclk_i) begin
        if (chk_en) begin
            check("pready", 32'(pready_o),
                  32'((ph == PH_UNSEQ) || ((ph == PH_ACC || ph == PH_ABORT) && ph_k == WS)));
            check("pslverr", 32'(pslverr_o),
                  32'((ph == PH_UNSEQ) ||
                      (ph == PH_ACC && ph_k == WS && m_err(paddr_i, pwrite_i, pstrb_i, m_empty))));
            check("prdata", prdata_o, m_prdata);
            check("tx_push", 32'(tx_push_o), 32'(m_push));
            check("tx_data", 32'(tx_data_o), 32'(m_tx));
            check("rx_pop", 32'(rx_pop_o), 32'(m_pop));
            check("slv_addr", 32'(reg_slave_address_o), 32'(m_slv));
            check("cmd", 32'(reg_command_o), 32'(m_cmd));
            check("prescale", 32'(reg_prescale_o), 32'(m_pre));
            check("irq", 32'(irq_o), 32'(|(m_stat & m_en)));
        end
    end

    task automatic step();
        if (rand_in) begin
            rx_data_i  = 8'($urandom);
            rx_empty_i = ($urandom_range(0, 3) == 0);
            status_i   = 8'($urandom);
            event_i    = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
        end
        #1;
        last_pready = pready_o;
        last_err    = pslverr_o;
        @(posedge pclk_i);
        #1;
        if (!rand_in) event_i = 4'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            ph = PH_IDLE;
            step();
        end
    endtask

    task automatic xfer(input logic [7:0] a, input bit wr, input logic [31:0] wd,
                        input logic [3:0] s, input int abort_at, input logic [3:0] ev_cpl);
        paddr_i = a; pwrite_i = wr; pwdata_i = wd; pstrb_i = s;
        psel_i = 1; penable_i = 0; ph = PH_SETUP;
        step();
        penable_i = 1;
        low_cnt = 0;
        for (int k = 0; k <= WS; k++) begin
            ph_k = k;
            if (k == abort_at) begin
                psel_i = 0; penable_i = 0; ph = PH_ABORT;
                step();
                break;
            end
            ph = PH_ACC;
            if (k == WS && ev_cpl != 4'h0) event_i = ev_cpl;
            step();
            if (!last_pready) low_cnt++;
        end
        psel_i = 0; penable_i = 0; ph = PH_IDLE;
    endtask

    task automatic unseq();
        psel_i = 1; penable_i = 1; ph = PH_UNSEQ;
        step();
        psel_i = 0; penable_i = 0; ph = PH_IDLE;
    endtask

    initial begin
        // Reset
        preset_i = 1;
        step();
        chk_en = 1;
        idle(2);
        preset_i = 0;
        idle(1);
        check("rst_prdata", prdata_o, 32'h0);
        check("rst_irq", 32'(irq_o), 32'h0);
        check("rst_prescale", 32'(reg_prescale_o), 32'h0);

        // TX write and read-back
        xfer(8'h00, 1, 32'hA5, 4'hF, -1, 4'h0);
        check("tx_push_pulse", 32'(tx_push_o), 32'h1);
        check("tx_data_val", 32'(tx_data_o), 32'hA5);
        check("tx_wr_err", 32'(last_err), 32'h0);
        idle(1);
        check("tx_push_single", 32'(tx_push_o), 32'h0);
        xfer(8'h00, 0, 32'h0, 4'h0, -1, 4'h0);
        check("tx_readback", prdata_o, 32'hA5);
        check("tx_rd_err", 32'(last_err), 32'h0);

        // Prescale with only lane 0 enabled, two wait states
        xfer(8'h14, 1, 32'h1234, 4'b0001, -1, 4'h0);
        check("pre_waits", low_cnt, WS);
        check("pre_lane0", 32'(reg_prescale_o), 32'h0034);

        // RX read, non-empty then empty
        rx_empty_i = 0; rx_data_i = 8'h5C;
        xfer(8'h04, 0, 32'h0, 4'h0, -1, 4'h0);
        check("rx_data", prdata_o, 32'h5C);
        check("rx_pop_pulse", 32'(rx_pop_o), 32'h1);
        check("rx_err0", 32'(last_err), 32'h0);
        idle(1);
        check("rx_pop_single", 32'(rx_pop_o), 32'h0);
        rx_empty_i = 1;
        xfer(8'h04, 0, 32'h0, 4'h0, -1, 4'h0);
        check("rx_empty_err", 32'(last_err), 32'h1);
        check("rx_empty_nopop", 32'(rx_pop_o), 32'h0);

        // Error writes leave registers untouched
        xfer(8'h0C, 1, 32'h4B, 4'hF, -1, 4'h0);
        xfer(8'h40, 1, 32'hFF, 4'hF, -1, 4'h0);
        check("unmapped_err", 32'(last_err), 32'h1);
        xfer(8'h08, 1, 32'hFF, 4'hF, -1, 4'h0);
        check("status_wr_err", 32'(last_err), 32'h1);
        xfer(8'h0C, 1, 32'h11, 4'h0, -1, 4'h0);
        check("nostrb_err", 32'(last_err), 32'h1);
        check("slv_kept", 32'(reg_slave_address_o), 32'h4B);

        // Unsequenced enable
        unseq();
        check("unseq_ready", 32'(last_pready), 32'h1);
        check("unseq_err", 32'(last_err), 32'h1);

        // Interrupts: enable, event, W1C racing a new event, then real clear
        xfer(8'h18, 1, 32'h2, 4'hF, -1, 4'h0);
        event_i = 4'h2; ph = PH_IDLE;
        step();
        check("irq_set", 32'(irq_o), 32'h1);
        xfer(8'h1C, 1, 32'h2, 4'hF, -1, 4'h2);
        check("irq_set_wins", 32'(irq_o), 32'h1);
        xfer(8'h1C, 1, 32'h2, 4'hF, -1, 4'h0);
        check("irq_cleared", 32'(irq_o), 32'h0);

        // Abort during a wait state
        xfer(8'h10, 1, 32'h77, 4'hF, 1, 4'h0);
        check("abort_no_write", 32'(reg_command_o), 32'h0);

        // Reset during a wait state of a TX write
        paddr_i = 8'h00; pwrite_i = 1; pwdata_i = 32'h3C; pstrb_i = 4'hF;
        psel_i = 1; penable_i = 0; ph = PH_SETUP;
        step();
        penable_i = 1; ph = PH_ACC; ph_k = 0; preset_i = 1;
        step();
        preset_i = 0; psel_i = 0; penable_i = 0; ph = PH_IDLE;
        #1;
        check("rstmid_push", 32'(tx_push_o), 32'h0);
        check("rstmid_txdata", 32'(tx_data_o), 32'h0);
        check("rstmid_prdata", prdata_o, 32'h0);
        check("rstmid_slv", 32'(reg_slave_address_o), 32'h0);
        check("rstmid_pready", 32'(pready_o), 32'h0);
        idle(3);

        // Randomized traffic
        rand_in = 1;
        for (int n = 0; n < 400; n++) begin
            int op;
            int ab;
            logic [3:0] s;
            op = $urandom_range(0, 11);
            if (op == 0) begin
                unseq();
            end else begin
                s  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
                ab = (op == 1 && WS > 0) ? int'($urandom_range(0, WS - 1)) : -1;
                xfer(8'($urandom_range(0, 9) * 4), 1'($urandom_range(0, 1)), $urandom, s, ab, 4'h0);
            end
            idle($urandom_range(0, 2));
        end
        rand_in = 0;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
